// File: rtl/weight_kernel_bank.sv
`default_nettype none
// ============================================================================
// Module   : weight_kernel_bank
// Desc     : Bank of signed KERNEL_HEIGHT x KERNEL_WIDTH weight kernels loaded
//            by raster-order valid/ready beats and read out combinationally.
//            Define WEIGHT_KERNEL_SHADOW_EN for double-buffered loads + swap.
// Revision : 1.0
// ============================================================================
module weight_kernel_bank #(
  parameter int                              KERNEL_WIDTH   = 3,
  parameter int                              KERNEL_HEIGHT  = 3,
  parameter int                              WEIGHT_WIDTH   = 8,
  parameter int                              NUM_KERNELS    = 4,
  parameter logic signed [WEIGHT_WIDTH-1:0]  DEFAULT_WEIGHT = 8'sb00100000
) (
  input  logic                                                              clk_i,
  input  logic                                                              rst_ni,
  input  logic                                                              load_valid_i,
  output logic                                                              load_ready_o,
  input  logic signed [WEIGHT_WIDTH-1:0]                                    load_data_i,
  input  logic [((NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1)-1:0]          load_kernel_i,
  input  logic                                                              swap_i,
  input  logic [((NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1)-1:0]          rd_kernel_i,
  output logic signed [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WEIGHT_WIDTH-1:0] weight_o,
  output logic [NUM_KERNELS-1:0]                                            pending_o,
  output logic                                                              busy_o
);

  localparam int c_N_ELEM = KERNEL_HEIGHT * KERNEL_WIDTH;
  localparam int c_KSEL_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam int c_CNT_W  = (c_N_ELEM > 1) ? $clog2(c_N_ELEM) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_e;

  state_e                          r_state;
  logic [c_CNT_W-1:0]              r_beat;
  logic [c_KSEL_W-1:0]             r_kern;
  logic                            r_busy;
  logic signed [WEIGHT_WIDTH-1:0]  r_active [NUM_KERNELS][c_N_ELEM];

  logic                            w_accept;
  logic                            w_last;
  logic                            w_kvalid;
  logic [c_KSEL_W-1:0]             w_kern;

  // The target kernel is taken straight from the port on the first beat and
  // from the latched copy for every later beat of the same load.
  assign w_kern   = (r_state == S_IDLE) ? load_kernel_i : r_kern;
  assign w_kvalid = (int'(w_kern) < NUM_KERNELS);
  assign w_accept = load_valid_i & load_ready_o;
  assign w_last   = (r_beat == c_CNT_W'(c_N_ELEM - 1));
  assign busy_o   = r_busy;

`ifdef WEIGHT_KERNEL_SHADOW_EN
  logic signed [WEIGHT_WIDTH-1:0]  r_shadow [NUM_KERNELS][c_N_ELEM];
  logic [NUM_KERNELS-1:0]          r_pending;

  assign load_ready_o = ~swap_i;
  assign pending_o    = r_pending;
`else
  logic w_unused_swap;

  assign w_unused_swap = swap_i;
  assign load_ready_o  = 1'b1;
  assign pending_o     = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_kern  <= '0;
      r_busy  <= 1'b0;
      for (int k = 0; k < NUM_KERNELS; k++) begin
        for (int i = 0; i < c_N_ELEM; i++) begin
          r_active[k][i] <= DEFAULT_WEIGHT;
`ifdef WEIGHT_KERNEL_SHADOW_EN
          r_shadow[k][i] <= DEFAULT_WEIGHT;
`endif
        end
      end
`ifdef WEIGHT_KERNEL_SHADOW_EN
      r_pending <= '0;
`endif
    end else begin
`ifdef WEIGHT_KERNEL_SHADOW_EN
      // load_ready_o is low while swapping, so no beat can race the copy.
      if (swap_i) begin
        for (int k = 0; k < NUM_KERNELS; k++) begin
          if (r_pending[k]) begin
            r_active[k]  <= r_shadow[k];
            r_pending[k] <= 1'b0;
          end
        end
      end
`endif
      if (w_accept) begin
        if (w_kvalid) begin
`ifdef WEIGHT_KERNEL_SHADOW_EN
          r_shadow[w_kern][r_beat] <= load_data_i;
          if (r_state == S_IDLE) begin
            r_pending[w_kern] <= 1'b0;
          end
          if (w_last) begin
            r_pending[w_kern] <= 1'b1;
          end
`else
          r_active[w_kern][r_beat] <= load_data_i;
`endif
        end
        if (r_state == S_IDLE) begin
          r_kern <= load_kernel_i;
        end
        if (w_last) begin
          r_state <= S_IDLE;
          r_beat  <= '0;
          r_busy  <= 1'b0;
        end else begin
          r_state <= S_LOAD;
          r_beat  <= r_beat + 1'b1;
          r_busy  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    weight_o = '0;
    if (int'(rd_kernel_i) < NUM_KERNELS) begin
      for (int r = 0; r < KERNEL_HEIGHT; r++) begin
        for (int c = 0; c < KERNEL_WIDTH; c++) begin
          weight_o[r][c] = r_active[rd_kernel_i][r*KERNEL_WIDTH + c];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_kernel_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_kernel_bank
// Desc     : Directed self-checking bench for weight_kernel_bank (both builds).
// Revision : 1.0
// ============================================================================
module tb_weight_kernel_bank;

  localparam int KW = 3;
  localparam int KH = 3;
  localparam int WW = 8;
  localparam int NK = 4;
`ifdef WEIGHT_KERNEL_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic                               clk_i = 1'b0;
  logic                               rst_ni = 1'b0;
  logic                               load_valid_i = 1'b0;
  logic                               load_ready_o;
  logic signed [WW-1:0]               load_data_i = '0;
  logic [1:0]                         load_kernel_i = '0;
  logic                               swap_i = 1'b0;
  logic [1:0]                         rd_kernel_i = '0;
  logic signed [KH-1:0][KW-1:0][WW-1:0] weight_o;
  logic [NK-1:0]                      pending_o;
  logic                               busy_o;

  int checks = 0;
  int errors = 0;

  weight_kernel_bank #(
    .KERNEL_WIDTH  (KW),
    .KERNEL_HEIGHT (KH),
    .WEIGHT_WIDTH  (WW),
    .NUM_KERNELS   (NK)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .load_valid_i  (load_valid_i),
    .load_ready_o  (load_ready_o),
    .load_data_i   (load_data_i),
    .load_kernel_i (load_kernel_i),
    .swap_i        (swap_i),
    .rd_kernel_i   (rd_kernel_i),
    .weight_o      (weight_o),
    .pending_o     (pending_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_beat(input logic [WW-1:0] d, input logic [1:0] k);
    load_valid_i  = 1'b1;
    load_data_i   = d;
    load_kernel_i = k;
    tick();
    load_valid_i  = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_i = 1'b1;
    tick();
    swap_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    rd_kernel_i = 2'd0;
    #1;
    for (int r = 0; r < KH; r++) begin
      for (int c = 0; c < KW; c++) begin
        checks++;
        if (weight_o[r][c] !== 8'h20) begin
          errors++;
          $display("FAIL reset_w[%0d][%0d] got %h exp 20", r, c, weight_o[r][c]);
        end
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", busy_o);
    end
    checks++;
    if (pending_o !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pending got %b exp 0000", pending_o);
    end
    checks++;
    if (load_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", load_ready_o);
    end
  endtask

  // Kernel 0 gets -7 then 1..8.
  task automatic test_direct_write();
    logic [WW-1:0] exp;
    rd_kernel_i = 2'd0;
    send_beat(8'hF9, 2'd0);
    checks++;
    exp = SHADOW ? 8'h20 : 8'hF9;
    if (weight_o[0][0] !== exp) begin
      errors++;
      $display("FAIL direct_w00 got %h exp %h", weight_o[0][0], exp);
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL direct_busy got %b exp 1", busy_o);
    end
    checks++;
    if (weight_o[0][1] !== 8'h20) begin
      errors++;
      $display("FAIL direct_w01_untouched got %h exp 20", weight_o[0][1]);
    end
    for (int i = 1; i < KH*KW; i++) send_beat(8'(i), 2'd0);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL direct_busy_end got %b exp 0", busy_o);
    end
    pulse_swap();
    for (int i = 0; i < KH*KW; i++) begin
      exp = (i == 0) ? 8'hF9 : 8'(i);
      checks++;
      if (weight_o[i/KW][i%KW] !== exp) begin
        errors++;
        $display("FAIL direct_w[%0d] got %h exp %h", i, weight_o[i/KW][i%KW], exp);
      end
    end
  endtask

  // Kernel 1 gets 1..9; visible only after swap when double-buffered.
  task automatic test_load_commit();
    logic [WW-1:0] exp;
    for (int i = 0; i < KH*KW; i++) send_beat(8'(i + 1), 2'd1);
    rd_kernel_i = 2'd1;
    #1;
    checks++;
    exp = SHADOW ? 8'h20 : 8'h01;
    if (weight_o[0][0] !== exp) begin
      errors++;
      $display("FAIL commit_pre_w00 got %h exp %h", weight_o[0][0], exp);
    end
    checks++;
    if (pending_o !== (SHADOW ? 4'b0010 : 4'b0000)) begin
      errors++;
      $display("FAIL commit_pending got %b exp %b", pending_o, SHADOW ? 4'b0010 : 4'b0000);
    end
    swap_i = 1'b1;
    #1;
    checks++;
    if (load_ready_o !== !SHADOW) begin
      errors++;
      $display("FAIL commit_ready_swap got %b exp %b", load_ready_o, !SHADOW);
    end
    tick();
    swap_i = 1'b0;
    for (int i = 0; i < KH*KW; i++) begin
      checks++;
      if (weight_o[i/KW][i%KW] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL commit_w[%0d] got %h exp %h", i, weight_o[i/KW][i%KW], 8'(i + 1));
      end
    end
    checks++;
    if (pending_o !== 4'b0000) begin
      errors++;
      $display("FAIL commit_pending_clr got %b exp 0000", pending_o);
    end
  endtask

  // Kernel 2 gets 0x10+i with three idle cycles between beats.
  task automatic test_gaps();
    logic [WW-1:0] exp;
    rd_kernel_i = 2'd2;
    for (int i = 0; i < KH*KW; i++) begin
      send_beat(8'(8'h10 + i), 2'd2);
      if (i < KH*KW - 1) begin
        for (int g = 0; g < 3; g++) begin
          checks++;
          if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL gaps_busy beat %0d gap %0d got %b exp 1", i, g, busy_o);
          end
          tick();
        end
        exp = SHADOW ? 8'h20 : 8'(8'h10 + i);
        checks++;
        if (weight_o[i/KW][i%KW] !== exp) begin
          errors++;
          $display("FAIL gaps_inflight_w[%0d] got %h exp %h", i, weight_o[i/KW][i%KW], exp);
        end
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL gaps_busy_end got %b exp 0", busy_o);
    end
    pulse_swap();
    for (int i = 0; i < KH*KW; i++) begin
      checks++;
      if (weight_o[i/KW][i%KW] !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL gaps_w[%0d] got %h exp %h", i, weight_o[i/KW][i%KW], 8'(8'h10 + i));
      end
    end
  endtask

  // Kernel 0 reloaded with 0xA0+i; swap pulsed between beats 4 and 5.
  task automatic test_swap_mid_load();
    logic [WW-1:0] exp;
    rd_kernel_i = 2'd0;
    for (int i = 0; i < 5; i++) send_beat(8'(8'hA0 + i), 2'd0);
    swap_i = 1'b1;
    #1;
    checks++;
    if (load_ready_o !== !SHADOW) begin
      errors++;
      $display("FAIL midswap_ready got %b exp %b", load_ready_o, !SHADOW);
    end
    tick();
    swap_i = 1'b0;
    exp = SHADOW ? 8'hF9 : 8'hA0;
    checks++;
    if (weight_o[0][0] !== exp) begin
      errors++;
      $display("FAIL midswap_w00 got %h exp %h", weight_o[0][0], exp);
    end
    checks++;
    if (pending_o !== 4'b0000) begin
      errors++;
      $display("FAIL midswap_pending got %b exp 0000", pending_o);
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midswap_busy got %b exp 1", busy_o);
    end
    for (int i = 5; i < KH*KW; i++) send_beat(8'(8'hA0 + i), 2'd0);
    checks++;
    if (pending_o !== (SHADOW ? 4'b0001 : 4'b0000)) begin
      errors++;
      $display("FAIL midswap_pending_done got %b exp %b", pending_o, SHADOW ? 4'b0001 : 4'b0000);
    end
    pulse_swap();
    for (int i = 0; i < KH*KW; i++) begin
      checks++;
      if (weight_o[i/KW][i%KW] !== 8'(8'hA0 + i)) begin
        errors++;
        $display("FAIL midswap_w[%0d] got %h exp %h", i, weight_o[i/KW][i%KW], 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 4; i++) send_beat(8'h55, 2'd3);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy got %b exp 0", busy_o);
    end
    checks++;
    if (pending_o !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_pending got %b exp 0000", pending_o);
    end
    for (int k = 0; k < NK; k++) begin
      rd_kernel_i = 2'(k);
      #1;
      for (int i = 0; i < KH*KW; i++) begin
        checks++;
        if (weight_o[i/KW][i%KW] !== 8'h20) begin
          errors++;
          $display("FAIL rstmid_k%0d_w[%0d] got %h exp 20", k, i, weight_o[i/KW][i%KW]);
        end
      end
    end
    // A fresh load after reset must start again at element [0][0].
    rd_kernel_i = 2'd3;
    for (int i = 0; i < KH*KW; i++) send_beat(8'(8'h70 + i), 2'd3);
    pulse_swap();
    checks++;
    if (weight_o[0][0] !== 8'h70) begin
      errors++;
      $display("FAIL rstmid_reload_w00 got %h exp 70", weight_o[0][0]);
    end
    checks++;
    if (weight_o[2][2] !== 8'h78) begin
      errors++;
      $display("FAIL rstmid_reload_w22 got %h exp 78", weight_o[2][2]);
    end
  endtask

  // Target changes after beat 0 must be ignored: all data lands in kernel 1.
  task automatic test_kernel_latch();
    send_beat(8'h30, 2'd1);
    for (int i = 1; i < KH*KW; i++) send_beat(8'(8'h30 + i), 2'd2);
    checks++;
    if (pending_o !== (SHADOW ? 4'b0010 : 4'b0000)) begin
      errors++;
      $display("FAIL latch_pending got %b exp %b", pending_o, SHADOW ? 4'b0010 : 4'b0000);
    end
    pulse_swap();
    rd_kernel_i = 2'd1;
    #1;
    for (int i = 0; i < KH*KW; i++) begin
      checks++;
      if (weight_o[i/KW][i%KW] !== 8'(8'h30 + i)) begin
        errors++;
        $display("FAIL latch_k1_w[%0d] got %h exp %h", i, weight_o[i/KW][i%KW], 8'(8'h30 + i));
      end
    end
    rd_kernel_i = 2'd2;
    #1;
    checks++;
    if (weight_o[1][1] !== 8'h20) begin
      errors++;
      $display("FAIL latch_k2_w11 got %h exp 20", weight_o[1][1]);
    end
  endtask

  // Two loads with valid held continuously across the kernel boundary.
  task automatic test_back_to_back();
    for (int i = 0; i < KH*KW; i++) send_beat(8'(8'hC0 + i), 2'd0);
    for (int i = 0; i < KH*KW; i++) send_beat(8'(8'hD0 + i), 2'd2);
    checks++;
    if (pending_o !== (SHADOW ? 4'b0101 : 4'b0000)) begin
      errors++;
      $display("FAIL b2b_pending got %b exp %b", pending_o, SHADOW ? 4'b0101 : 4'b0000);
    end
    pulse_swap();
    rd_kernel_i = 2'd0;
    #1;
    checks++;
    if (weight_o[2][1] !== 8'hC7) begin
      errors++;
      $display("FAIL b2b_k0_w21 got %h exp c7", weight_o[2][1]);
    end
    rd_kernel_i = 2'd2;
    #1;
    checks++;
    if (weight_o[0][0] !== 8'hD0) begin
      errors++;
      $display("FAIL b2b_k2_w00 got %h exp d0", weight_o[0][0]);
    end
    checks++;
    if (weight_o[2][2] !== 8'hD8) begin
      errors++;
      $display("FAIL b2b_k2_w22 got %h exp d8", weight_o[2][2]);
    end
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_load_commit();
    test_gaps();
    test_swap_mid_load();
    test_reset_mid_load();
    test_kernel_latch();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/weight_kernel_bank.md
WEIGHT_KERNEL_BANK -- requirements
Module: weight_kernel_bank

Interface
REQ-001 SHALL have parameter KERNEL_WIDTH, default 3, kernel columns.
REQ-002 SHALL have parameter KERNEL_HEIGHT, default 3, kernel rows.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8, signed weight width.
REQ-004 SHALL have parameter NUM_KERNELS, default 4, number of stored kernels (>=1).
REQ-005 SHALL have parameter DEFAULT_WEIGHT, default 8'sb00100000, reset value of every weight.
REQ-006 SHALL have port clk_i, input, 1, sole clock; rising edge.
REQ-007 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-008 SHALL have port load_valid_i, input, 1, load beat valid.
REQ-009 SHALL have port load_ready_o, output, 1, load beat accepted when high with load_valid_i.
REQ-010 SHALL have port load_data_i, input, WEIGHT_WIDTH, signed weight beat.
REQ-011 SHALL have port load_kernel_i, input, $clog2(NUM_KERNELS) (min 1), target kernel; sampled on first beat only.
REQ-012 SHALL have port swap_i, input, 1, pulse: commit pending shadow kernels to active.
REQ-013 SHALL have port rd_kernel_i, input, $clog2(NUM_KERNELS) (min 1), kernel selected onto weight_o.
REQ-014 SHALL have port weight_o, output, KERNEL_HEIGHT*KERNEL_WIDTH*WEIGHT_WIDTH, packed signed [H-1:0][W-1:0][WEIGHT_WIDTH-1:0] active kernel; element [r][c] at row r, column c.
REQ-015 SHALL have port pending_o, output, NUM_KERNELS, bit k high when kernel k has a complete uncommitted load.
REQ-016 SHALL have port busy_o, output, 1, high while a load is in progress.

Function
REQ-017 SHALL implement FSM states IDLE and LOAD; IDLE->LOAD on first accepted beat; LOAD->IDLE on accepting beat N=KERNEL_HEIGHT*KERNEL_WIDTH.
REQ-018 SHALL accept beats in raster order: beat i writes element [i/KERNEL_WIDTH][i%KERNEL_WIDTH] of the target kernel's shadow storage.
REQ-019 SHALL latch load_kernel_i on the first beat; later changes during LOAD ignored.
REQ-020 SHALL drive load_ready_o high in IDLE and LOAD except during the cycle swap_i is sampled high.
REQ-021 SHALL hold the beat counter and shadow storage unchanged in cycles where load_valid_i is low (gaps allowed).
REQ-022 SHALL set pending_o[k] one cycle after the final beat of kernel k is accepted.
REQ-023 SHALL, on swap_i high, copy every shadow kernel with pending bit set into active storage and clear those pending bits; visible on weight_o the next cycle.
REQ-024 SHALL ignore swap_i for kernels with no pending bit; swap during LOAD SHALL NOT commit the partially loaded kernel.
REQ-025 SHALL let a reload of a pending kernel overwrite its shadow; pending bit clears on first beat and sets again on completion.
REQ-026 SHALL drive weight_o combinationally from active storage of rd_kernel_i; rd_kernel_i >= NUM_KERNELS SHALL yield all-zero weight_o.
REQ-027 SHALL drop beats targeting load_kernel_i >= NUM_KERNELS (accepted, counted, not stored, no pending bit set).
REQ-028 SHALL store weights verbatim; no arithmetic or saturation.

Reset
REQ-029 SHALL, on rising clk_i with rst_ni low: active and shadow weights = DEFAULT_WEIGHT, FSM = IDLE, beat counter = 0, pending_o = 0, busy_o = 0, load_ready_o = 1 from the first cycle after reset.
REQ-030 SHALL abandon an in-progress load on reset mid-operation; no partial data becomes active.

Configuration
REQ-031 SHALL compile double buffering in only when macro WEIGHT_KERNEL_SHADOW_EN is defined.
REQ-032 SHALL, without WEIGHT_KERNEL_SHADOW_EN, write beats directly to active storage (visible on weight_o the cycle after each beat), tie pending_o to 0, and ignore swap_i (load_ready_o never drops for swap).

Verification
REQ-033 SHALL cover: reset, rd_kernel_i=0 -> all 9 elements of weight_o = 0x20.
REQ-034 SHALL cover (shadow on): load kernel 1 with beats 1..9, rd_kernel_i=1 -> weight_o unchanged (0x20), pending_o=4'b0010; pulse swap_i -> next cycle [0][0]=1, [2][2]=9, pending_o=0.
REQ-035 SHALL cover: load of kernel 2 with load_valid_i gaps of 3 cycles between beats -> same result as gapless load; busy_o high throughout.
REQ-036 SHALL cover: swap_i pulsed after beat 5 of kernel 0 -> kernel 0 active unchanged, load_ready_o low that cycle, load completes, pending_o[0] set.
REQ-037 SHALL cover: rst_ni low after beat 4 of kernel 3 -> all kernels 0x20, busy_o=0, pending_o=0.
REQ-038 SHALL cover (shadow off): beat 0 value -7 to kernel 0 -> weight_o[0][0] = -7 (0xF9) next cycle.
